nphy_toggle_rb_monitor: RTL and testbench

- Parametrised successor to the PHY top's fixed 2-flop Ready/Busy capture.
- Synchronises N raw R/B# pins into iSystemClock with a configurable stage count.
- Per way: glitch-filters the pin, emits busy/ready edge pulses, and flags stuck-busy timeouts.
- Sits between the pinpad R/B# outputs and the way scheduler; replaces the plain synchroniser in the next-generation NPhy top.

---
 rtl/nphy_rb_pkg.sv | 22 ++
 rtl/nphy_rb_way.sv | 94 +++++++++
 rtl/nphy_toggle_rb_monitor.sv | 54 +++++
 tb/tb_nphy_toggle_rb_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nphy_rb_pkg.sv
// Shared constants and helpers for the NPhy Ready/Busy monitor.
// Event counters are built only when NPHY_RB_EVENT_COUNT_EN is defined.
package nphy_rb_pkg;

  localparam logic RB_READY = 1'b1;
  localparam logic RB_BUSY  = 1'b0;

  localparam int DefaultTimeoutWidth = 24;
  localparam int DefaultFilterCycles = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int FilterCntWidth = clog2(DefaultFilterCycles + 1);

endpackage

// File: rtl/nphy_rb_way.sv
// One R/B# way: synchroniser, glitch filter, edge pulses, busy timer and sticky timeout.
// The per-way rise counter exists only when NPHY_RB_EVENT_COUNT_EN is defined.
module nphy_rb_way
  import nphy_rb_pkg::*;
#(
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4,
  parameter int TimeoutWidth = DefaultTimeoutWidth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pin,
  input  logic                    mask,
  input  logic [TimeoutWidth-1:0] limit,
  input  logic                    clear,
`ifdef NPHY_RB_EVENT_COUNT_EN
  input  logic                    count_clear,
  output logic [7:0]              count,
`endif
  output logic                    ready,
  output logic                    rise,
  output logic                    fall,
  output logic                    timeout
);

  localparam int CntW = clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

  logic [SyncStages-1:0]   sync;
  logic                    sample;
  logic [CntW-1:0]         cnt;
  logic [TimeoutWidth-1:0] timer;
  logic                    qualify;
  logic                    set_cond;

  assign sample   = sync[SyncStages-1];
  // The filtered state flips on the edge where the last differing sample is counted.
  assign qualify  = (sample != ready) && (cnt == CntLast);
  assign set_cond = (limit != '0) && (timer >= limit) && !mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      ready   <= RB_BUSY;
      rise    <= 1'b0;
      fall    <= 1'b0;
      timer   <= '0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SyncStages-2:0], pin};

      if (sample == ready) begin
        cnt <= '0;
      end else if (qualify) begin
        ready <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      rise <= qualify && (sample == RB_READY) && !mask;
      fall <= qualify && (sample == RB_BUSY) && !mask;

      if (ready == RB_READY || mask) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 1'b1;
      end

      // Set has priority over clear so a clear during a live condition is ignored.
      if (mask) begin
        timeout <= 1'b0;
      end else if (set_cond) begin
        timeout <= 1'b1;
      end else if (clear) begin
        timeout <= 1'b0;
      end
    end
  end

`ifdef NPHY_RB_EVENT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count_clear) begin
      count <= '0;
    end else if (rise && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/nphy_toggle_rb_monitor.sv
// NPhy Ready/Busy monitor: N filtered R/B# ways plus an all-ready summary.
// Define NPHY_RB_EVENT_COUNT_EN to add per-way rise counters (iCountClear/oRiseCount).
module nphy_toggle_rb_monitor
  import nphy_rb_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4,
  parameter int TimeoutWidth = DefaultTimeoutWidth
) (
  input  logic                      iSystemClock,
  input  logic                      iModuleReset_n,
  input  logic [NumberOfWays-1:0]   iRBFromNAND,
  input  logic [NumberOfWays-1:0]   iWayMask,
  input  logic [TimeoutWidth-1:0]   iTimeoutLimit,
  input  logic [NumberOfWays-1:0]   iTimeoutClear,
`ifdef NPHY_RB_EVENT_COUNT_EN
  input  logic [NumberOfWays-1:0]   iCountClear,
  output logic [8*NumberOfWays-1:0] oRiseCount,
`endif
  output logic [NumberOfWays-1:0]   oReadyBusy,
  output logic [NumberOfWays-1:0]   oReadyRise,
  output logic [NumberOfWays-1:0]   oBusyFall,
  output logic [NumberOfWays-1:0]   oTimeout,
  output logic                      oAllReady
);

  for (genvar w = 0; w < NumberOfWays; w++) begin : g_way
    nphy_rb_way #(
      .SyncStages  (SyncStages),
      .FilterCycles(FilterCycles),
      .TimeoutWidth(TimeoutWidth)
    ) u_way (
      .clk        (iSystemClock),
      .rst_n      (iModuleReset_n),
      .pin        (iRBFromNAND[w]),
      .mask       (iWayMask[w]),
      .limit      (iTimeoutLimit),
      .clear      (iTimeoutClear[w]),
`ifdef NPHY_RB_EVENT_COUNT_EN
      .count_clear(iCountClear[w]),
      .count      (oRiseCount[8*w +: 8]),
`endif
      .ready      (oReadyBusy[w]),
      .rise       (oReadyRise[w]),
      .fall       (oBusyFall[w]),
      .timeout    (oTimeout[w])
    );
  end

  // Masked ways count as ready, so an all-masked monitor reports 1 even in reset.
  assign oAllReady = &(oReadyBusy | iWayMask);

endmodule

// File: tb/tb_nphy_toggle_rb_monitor.sv
// Directed bench for nphy_toggle_rb_monitor (4 ways, 2 sync stages, filter 4).
module tb_nphy_toggle_rb_monitor;

  localparam int N  = 4;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  rb;
  logic [N-1:0]  mask;
  logic [TW-1:0] limit;
  logic [N-1:0]  tclr;
  logic [N-1:0]  ready, rise, fall, tout;
  logic          all_ready;
`ifdef NPHY_RB_EVENT_COUNT_EN
  logic [N-1:0]   cclr;
  logic [8*N-1:0] rcount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nphy_toggle_rb_monitor #(
    .NumberOfWays(N),
    .SyncStages  (2),
    .FilterCycles(4),
    .TimeoutWidth(TW)
  ) dut (
    .iSystemClock  (clk),
    .iModuleReset_n(rst_n),
    .iRBFromNAND   (rb),
    .iWayMask      (mask),
    .iTimeoutLimit (limit),
    .iTimeoutClear (tclr),
`ifdef NPHY_RB_EVENT_COUNT_EN
    .iCountClear   (cclr),
    .oRiseCount    (rcount),
`endif
    .oReadyBusy    (ready),
    .oReadyRise    (rise),
    .oBusyFall     (fall),
    .oTimeout      (tout),
    .oAllReady     (all_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rb    = 4'hF;
    mask  = 4'hF;
    limit = '0;
    tclr  = '0;
`ifdef NPHY_RB_EVENT_COUNT_EN
    cclr  = '0;
`endif
    step(2);
    chk("rst_all_masked_allready", all_ready, 1);
    mask = 4'h0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_timeout", tout, 0);
    chk("rst_allready", all_ready, 0);

    // release between edges; pins already high rise together after 6 edges
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("post_rst_ready_low", ready, 0);
      chk("post_rst_no_rise", rise, 0);
    end
    step(1);
    chk("post_rst_ready", ready, 4'hF);
    chk("post_rst_rise", rise, 4'hF);
    chk("post_rst_allready", all_ready, 1);
    step(1);
    chk("post_rst_rise_1cyc", rise, 0);
    chk("post_rst_ready_hold", ready, 4'hF);

    // 3-cycle glitch on way 1 is filtered out
    rb[1] = 1'b0;
    step(3);
    rb[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("glitch_ready", ready, 4'hF);
      chk("glitch_no_fall", fall, 0);
    end

    // real fall on way 1: pulse on the 6th edge
    rb[1] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("fall1_wait", fall, 0);
    end
    step(1);
    chk("fall1_pulse", fall, 4'b0010);
    chk("fall1_ready", ready, 4'b1101);
    chk("fall1_allready", all_ready, 0);
    step(1);
    chk("fall1_pulse_1cyc", fall, 0);
    rb[1] = 1'b1;
    step(6);
    chk("rise1_pulse", rise, 4'b0010);
    chk("rise1_ready", ready, 4'hF);

    // timeout on way 2, limit 100
    limit = 24'd100;
    rb[2] = 1'b0;
    step(6);
    chk("to_fall2", fall, 4'b0100);
    step(100);
    chk("to_not_yet", tout, 0);
    step(1);
    chk("to_set", tout, 4'b0100);
    tclr = 4'b0100;
    step(1);
    tclr = 4'b0000;
    chk("to_clear_while_busy", tout, 4'b0100);
    rb[2] = 1'b1;
    step(6);
    chk("to_rise2", rise, 4'b0100);
    step(1);
    chk("to_survives_ready", tout, 4'b0100);
    tclr = 4'b0100;
    step(1);
    tclr = 4'b0000;
    chk("to_cleared", tout, 0);

    // way 3 masked: no events, no timeout, ignored by all-ready
    mask = 4'b1000;
    rb[3] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("mask_no_fall", fall, 0);
    end
    chk("mask_ready_unmasked", ready, 4'b0111);
    chk("mask_allready", all_ready, 1);
    step(110);
    chk("mask_no_timeout", tout, 0);
    rb[0] = 1'b0;
    step(6);
    chk("mask_fall0", fall, 4'b0001);
    chk("mask_allready_low", all_ready, 0);
    rb[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("mask_no_rise3", rise, 0);
    end
    chk("mask_ready3", ready, 4'b1110);
    rb[0] = 1'b1;
    step(6);
    chk("mask_rise0", rise, 4'b0001);
    chk("mask_allready_back", all_ready, 1);
    mask = 4'b0000;

    // reset mid-busy with t=50 on way 1, then timer restarts from 0
    rb[1] = 1'b0;
    step(6);
    chk("rmb_fall1", fall, 4'b0010);
    step(50);
    chk("rmb_no_timeout", tout, 0);
    rst_n = 1'b0;
    #1;
    chk("rmb_ready", ready, 0);
    chk("rmb_timeout", tout, 0);
    chk("rmb_fall", fall, 0);
    chk("rmb_allready", all_ready, 0);
    step(1);
    rst_n = 1'b1;
    step(6);
    chk("rmb_rise", rise, 4'b1101);
    step(94);
    chk("rmb_restart_not_yet", tout, 0);
    step(1);
    chk("rmb_restart_set", tout, 4'b0010);
    rb[1] = 1'b1;
    step(7);
    tclr = 4'b0010;
    step(1);
    tclr = 4'b0000;
    chk("rmb_cleared", tout, 0);

`ifdef NPHY_RB_EVENT_COUNT_EN
    cclr = 4'b0001;
    step(1);
    cclr = 4'b0000;
    for (int k = 0; k < 300; k++) begin
      rb[0] = 1'b0;
      step(6);
      rb[0] = 1'b1;
      step(6);
    end
    chk("cnt_saturate", rcount[7:0], 8'hFF);
    cclr = 4'b0001;
    step(1);
    cclr = 4'b0000;
    chk("cnt_clear", rcount[7:0], 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
